// File: rtl/i2s_tx_sequencer_if.sv
// Upstream sample-pair handshake for the I2S transmit sequencer.
// The producer drives {in_left, in_right} and is accepted on in_valid && in_ready.
interface i2s_tx_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: 2-deep pair FIFO, frame-locked bit scheduler, underrun report.
// Optional macro I2S_TX_UNDERRUN_COUNT_EN adds the 8-bit saturating underrun counter.
module i2s_tx_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                sck,
  input  logic [5:0]          frame_posn,
  i2s_tx_sequencer_if.slave   up,
  output logic                sd,
  output logic                frame_start,
  output logic                underrun,
  output logic [7:0]          underrun_count
);

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic             sck_prev_q, sck_prev_d;
  logic [5:0]       p_prev_q, p_prev_d;
  logic             sd_q, sd_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic [WIDTH-1:0] tx_l_q, tx_l_d;
  logic [WIDTH-1:0] tx_r_q, tx_r_d;

  logic [2*WIDTH-1:0] mem_q [2];
  logic [2*WIDTH-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;

  logic        fe;
  logic        push;
  logic        pop;
  logic        start;
  logic        slip;
  logic        slot_bit;
  logic [31:0] l_word;
  logic [31:0] r_word;

  assign fe          = sck_prev_q & ~sck;
  assign up.in_ready = (count_q != 2'd2);
  assign push        = up.in_valid & up.in_ready;
  assign pop         = start & (count_q != 2'd0);
  assign slip        = (frame_posn != p_prev_q + 6'd1);

  // Words are MSB-aligned at bit 30 so slot n reads bit 31-n.
  assign l_word   = 32'({1'b0, tx_l_q}) << (31 - WIDTH);
  assign r_word   = 32'({1'b0, tx_r_q}) << (31 - WIDTH);
  assign slot_bit = frame_posn[5] ? r_word[~frame_posn[4:0]]
                                  : l_word[~frame_posn[4:0]];

  always_comb begin
    state_d = state_q;
    sd_d    = sd_q;
    start   = 1'b0;
    unique case (state_q)
      SYNC: begin
        sd_d = 1'b0;
        if (fe && frame_posn == 6'd0) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (fe) begin
          if (slip) begin
            state_d = SYNC;
            sd_d    = 1'b0;
          end else begin
            sd_d  = slot_bit;
            start = (frame_posn == 6'd0);
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    sck_prev_d = sck;
    p_prev_d   = fe ? frame_posn : p_prev_q;
    fs_d       = start;
    ur_d       = start & ~pop;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    if (start) begin
      if (pop) begin
        {tx_l_d, tx_r_d} = mem_q[rd_ptr_q];
      end else begin
        tx_l_d = '0;
        tx_r_d = '0;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (push) begin
      mem_d[wr_ptr_q] = {up.in_left, up.in_right};
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      sck_prev_q <= 1'b0;
      p_prev_q   <= 6'd0;
      sd_q       <= 1'b0;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_prev_d;
      p_prev_q   <= p_prev_d;
      sd_q       <= sd_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef I2S_TX_UNDERRUN_COUNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (ur_d && ucnt_q != 8'hFF) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ucnt_q <= 8'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`else
  assign underrun_count = 8'd0;
`endif

  assign sd          = sd_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule
